// File: rtl/mem_port_sched.sv
// Arbitrates the MEM-stage data port between speculative loads and committed stores.
// Stores wait in an in-order buffer; loads win unless a hazard, a full buffer or starvation forces a drain.
module mem_port_sched #(
    parameter int SB_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        flush,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [31:0]                 ld_addr,
    input  logic [5:0]                  ld_alu_control,
    input  logic [31:0]                 ld_instr_num,
    input  logic [5:0]                  ld_map,
    input  logic                        st_valid,
    output logic                        st_ready,
    input  logic [31:0]                 st_addr,
    input  logic [31:0]                 st_data,
    input  logic [5:0]                  st_alu_control,
    input  logic [31:0]                 st_instr_num,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata,
    output logic [5:0]                  mem_alu_control,
    output logic [31:0]                 mem_instr_num,
    output logic [5:0]                  mem_map,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        drain_mode
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic { LOAD_PRI, DRAIN } state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [STV_W-1:0]   starve, starve_next;
    logic [CNT_W-1:0]   count_next;
    logic               hazard, enq, st_issue;
    logic [PTR_W-1:0]   age;

    logic [31:0] sb_addr  [SB_DEPTH];
    logic [31:0] sb_data  [SB_DEPTH];
    logic [5:0]  sb_alu   [SB_DEPTH];
    logic [31:0] sb_instr [SB_DEPTH];

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        hazard = 1'b0;
        age    = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            age = PTR_W'(i) - rd_ptr;
            if (CNT_W'(age) < sb_count && sb_addr[i][31:2] == ld_addr[31:2])
                hazard = 1'b1;
        end
        hazard = hazard & ld_valid;
    end

    // Output / control decode
    always_comb begin
        ld_ready   = (state == LOAD_PRI) && ld_valid && !flush && !hazard;
        st_ready   = (sb_count != CNT_W'(SB_DEPTH));
        st_issue   = (sb_count != '0) && !ld_ready;
        enq        = st_valid && st_ready;
        count_next = sb_count + CNT_W'(enq) - CNT_W'(st_issue);
        drain_mode = (state == DRAIN);
        starve_next = starve;
        if (st_issue)
            starve_next = '0;
        else if (state == LOAD_PRI && sb_count != '0 && starve != STV_W'(STARVE_LIMIT))
            starve_next = starve + 1'b1;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            LOAD_PRI: if (count_next == CNT_W'(SB_DEPTH) ||
                          starve_next == STV_W'(STARVE_LIMIT) || hazard)
                          state_next = DRAIN;
            DRAIN:    if (count_next == '0)
                          state_next = LOAD_PRI;
            default:  state_next = LOAD_PRI;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= LOAD_PRI;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sb_count <= '0;
            starve   <= '0;
        end else begin
            state    <= state_next;
            sb_count <= count_next;
            if (enq)      wr_ptr <= wr_ptr + 1'b1;
            if (st_issue) rd_ptr <= rd_ptr + 1'b1;
            starve   <= (state == LOAD_PRI && state_next == DRAIN) ? '0 : starve_next;
        end
    end

    // NOTE: buffer storage is not reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge CLK) begin
        if (enq) begin
            sb_addr[wr_ptr]  <= st_addr;
            sb_data[wr_ptr]  <= st_data;
            sb_alu[wr_ptr]   <= st_alu_control;
            sb_instr[wr_ptr] <= st_instr_num;
        end
    end

    // Issue register toward MEM; fields hold when idle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_alu_control <= '0;
            mem_instr_num   <= '0;
            mem_map         <= '0;
        end else if (ld_ready) begin
            mem_read        <= 1'b1;
            mem_write       <= 1'b0;
            mem_addr        <= ld_addr;
            mem_wdata       <= '0;
            mem_alu_control <= ld_alu_control;
            mem_instr_num   <= ld_instr_num;
            mem_map         <= ld_map;
        end else if (st_issue) begin
            mem_read        <= 1'b0;
            mem_write       <= 1'b1;
            mem_addr        <= sb_addr[rd_ptr];
            mem_wdata       <= sb_data[rd_ptr];
            mem_alu_control <= sb_alu[rd_ptr];
            mem_instr_num   <= sb_instr[rd_ptr];
            mem_map         <= '0;
        end else begin
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched: loads, store fill, full drain, hazard, starvation, flush and reset.
module tb_mem_port_sched;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        flush, ld_valid, ld_ready, st_valid, st_ready;
    logic [31:0] ld_addr, ld_instr_num, st_addr, st_data, st_instr_num;
    logic [5:0]  ld_alu_control, ld_map, st_alu_control;
    logic        mem_read, mem_write, drain_mode;
    logic [31:0] mem_addr, mem_wdata, mem_instr_num;
    logic [5:0]  mem_alu_control, mem_map;
    logic [2:0]  sb_count;

    int n_checks = 0;
    int n_fails  = 0;

    mem_port_sched #(.SB_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .CLK(CLK), .RESET(RESET), .flush(flush),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_alu_control(ld_alu_control), .ld_instr_num(ld_instr_num), .ld_map(ld_map),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .st_alu_control(st_alu_control), .st_instr_num(st_instr_num),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_alu_control(mem_alu_control),
        .mem_instr_num(mem_instr_num), .mem_map(mem_map),
        .sb_count(sb_count), .drain_mode(drain_mode)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_load(input logic v, input logic [31:0] a, input logic [31:0] n, input logic [5:0] m);
        ld_valid = v; ld_addr = a; ld_instr_num = n; ld_map = m; ld_alu_control = 6'h03;
    endtask

    task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [31:0] n);
        st_valid = v; st_addr = a; st_data = d; st_instr_num = n; st_alu_control = 6'h08;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; flush = 1'b0;
        set_load(0, 0, 0, 0);
        set_store(0, 0, 0, 0);
        #1;
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_sb_count", sb_count, 0);
        check("rst_drain", drain_mode, 0);
        check("rst_st_ready", st_ready, 1);
        tick(); tick();
        RESET = 1'b1;
        tick();

        // Loads only
        for (int i = 0; i < 3; i++) begin
            set_load(1, 32'h100 + 32'(4*i), 32'(10+i), 6'(i+1));
            #1 check("ld_ready_loads", ld_ready, 1);
            tick();
            check("ld_mem_read", mem_read, 1);
            check("ld_mem_addr", mem_addr, 32'h100 + 32'(4*i));
            check("ld_mem_instr", mem_instr_num, 32'(10+i));
            check("ld_mem_map", mem_map, 32'(i+1));
            check("ld_mem_wdata", mem_wdata, 0);
        end
        set_load(0, 0, 0, 0);
        tick();
        check("ld_idle_read", mem_read, 0);
        check("ld_idle_addr_hold", mem_addr, 32'h108);

        // Store fill, no loads: each store issues the cycle after enqueue
        for (int i = 0; i < 4; i++) begin
            set_store(1, 32'h400 + 32'(4*i), 32'hA0 + 32'(i), 32'(20+i));
            #1 check("fill_st_ready", st_ready, 1);
            tick();
            check("fill_count", sb_count, 1);
            if (i > 0) begin
                check("fill_write", mem_write, 1);
                check("fill_addr", mem_addr, 32'h400 + 32'(4*(i-1)));
                check("fill_data", mem_wdata, 32'hA0 + 32'(i-1));
            end
        end
        set_store(0, 0, 0, 0);
        tick();
        check("fill_last_write", mem_write, 1);
        check("fill_last_addr", mem_addr, 32'h40C);
        check("fill_last_instr", mem_instr_num, 23);
        check("fill_last_map", mem_map, 0);
        check("fill_last_alu", mem_alu_control, 32'h08);
        check("fill_empty", sb_count, 0);
        tick();
        check("fill_idle_write", mem_write, 0);

        // Full buffer under continuous loads to 0x200
        set_load(1, 32'h200, 30, 6'd7);
        for (int i = 0; i < 4; i++) begin
            set_store(1, 32'h300 + 32'(4*i), 32'hB0 + 32'(i), 32'(50+i));
            #1 check("full_ld_ready", ld_ready, 1);
            tick();
            check("full_no_write", mem_write, 0);
            check("full_count", sb_count, 32'(i+1));
        end
        check("full_drain", drain_mode, 1);
        set_store(1, 32'h310, 32'hB4, 54);
        #1 check("full_st_ready_low", st_ready, 0);
        check("full_ld_blocked", ld_ready, 0);
        tick();
        check("full_w0", mem_addr, 32'h300);
        check("full_cnt_a", sb_count, 3);
        #1 check("full_st_ready_back", st_ready, 1);
        tick();
        check("full_w1", mem_addr, 32'h304);
        check("full_cnt_b", sb_count, 3);
        set_store(0, 0, 0, 0);
        for (int i = 2; i < 5; i++) begin
            tick();
            check("full_wr", mem_write, 1);
            check("full_wdata", mem_wdata, 32'hB0 + 32'(i));
        end
        check("full_end_count", sb_count, 0);
        check("full_end_drain", drain_mode, 0);
        #1 check("full_resume_ready", ld_ready, 1);
        tick();
        check("full_resume_read", mem_read, 1);
        check("full_resume_addr", mem_addr, 32'h200);
        set_load(0, 0, 0, 0);
        tick();

        // Hazard: store to 0x1002 then load to 0x1000
        set_store(1, 32'h1002, 32'h55, 40);
        tick();
        set_store(0, 0, 0, 0);
        set_load(1, 32'h1000, 41, 6'd5);
        #1 check("hz_ld_ready", ld_ready, 0);
        tick();
        check("hz_store_first", mem_write, 1);
        check("hz_store_addr", mem_addr, 32'h1002);
        check("hz_drain", drain_mode, 1);
        check("hz_count", sb_count, 0);
        #1 check("hz_ld_ready_drain", ld_ready, 0);
        tick();
        check("hz_gap_read", mem_read, 0);
        check("hz_exit_drain", drain_mode, 0);
        #1 check("hz_ld_ready_after", ld_ready, 1);
        tick();
        check("hz_load_read", mem_read, 1);
        check("hz_load_map", mem_map, 5);
        set_load(0, 0, 0, 0);
        tick();

        // Same word boundary: load to 0x1004 is not a hazard
        set_store(1, 32'h1002, 32'h66, 42);
        tick();
        set_store(0, 0, 0, 0);
        set_load(1, 32'h1004, 43, 6'd6);
        #1 check("nhz_ld_ready", ld_ready, 1);
        tick();
        check("nhz_read_addr", mem_addr, 32'h1004);
        check("nhz_count", sb_count, 1);
        check("nhz_drain", drain_mode, 0);
        set_load(0, 0, 0, 0);
        tick();
        check("nhz_store_issue", mem_write, 1);
        check("nhz_store_data", mem_wdata, 32'h66);
        tick();

        // Starvation: one store bypassed by 8 loads, then forced drain
        set_load(1, 32'h2000, 60, 6'd9);
        set_store(1, 32'h3000, 32'h77, 61);
        tick();
        set_store(0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            #1 check("stv_ld_ready", ld_ready, 1);
            check("stv_no_drain", drain_mode, 0);
            tick();
        end
        check("stv_drain", drain_mode, 1);
        check("stv_read_last", mem_read, 1);
        #1 check("stv_ld_blocked", ld_ready, 0);
        tick();
        check("stv_write", mem_write, 1);
        check("stv_write_addr", mem_addr, 32'h3000);
        check("stv_count", sb_count, 0);
        check("stv_exit", drain_mode, 0);
        set_load(0, 0, 0, 0);
        tick();

        // Flush kills the offered load
        set_load(1, 32'h500, 70, 6'd3);
        flush = 1'b1;
        #1 check("fl_ld_ready", ld_ready, 0);
        tick();
        check("fl_no_read", mem_read, 0);
        check("fl_addr_hold", mem_addr, 32'h3000);
        flush = 1'b0;
        set_load(0, 0, 0, 0);
        tick();

        // Reset with three stores buffered
        set_load(1, 32'h600, 80, 6'd2);
        for (int i = 0; i < 3; i++) begin
            set_store(1, 32'h700 + 32'(4*i), 32'hC0 + 32'(i), 32'(81+i));
            tick();
        end
        set_store(0, 0, 0, 0);
        set_load(0, 0, 0, 0);
        check("pre_rst_count", sb_count, 3);
        RESET = 1'b0;
        #1;
        check("mid_rst_read", mem_read, 0);
        check("mid_rst_write", mem_write, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_alu", mem_alu_control, 0);
        check("mid_rst_instr", mem_instr_num, 0);
        check("mid_rst_map", mem_map, 0);
        check("mid_rst_count", sb_count, 0);
        check("mid_rst_st_ready", st_ready, 1);
        check("mid_rst_drain", drain_mode, 0);
        #2 RESET = 1'b1;
        tick();
        check("post_rst_write", mem_write, 0);
        check("post_rst_count", sb_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
